// File: rtl/tone_pkg.sv
// Shared constants and types for the tone generator / tone meter pair.
// Holds clock and timeout defaults, the meter's state enum and its debug view.
package tone_pkg;

    localparam int CLK_F_DEF      = 50;
    localparam int CNT_W_DEF      = 21;
    localparam int TIMEOUT_US_DEF = 2000000;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } tone_state_e;

    typedef struct packed {
        tone_state_e state;
        logic        level;
    } tone_dbg_t;

endpackage

// File: rtl/tone_meter_sync_edge.sv
// Two-flop synchronizer plus history flop for an asynchronous input.
// Produces the synchronized level and single-cycle rise/fall pulses.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync;
    logic       hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b00;
            hist <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            hist <= sync[1];
        end
    end

    assign level = sync[1];
    assign rise  = sync[1] & ~hist;
    assign fall  = ~sync[1] & hist;

endmodule

// File: rtl/tone_meter.sv
// Measures period and high time of an asynchronous square wave in microseconds,
// with a one-cycle result strobe and timeout-based presence tracking.
module tone_meter
    import tone_pkg::*;
#(
    parameter int CLK_F      = CLK_F_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int TIMEOUT_US = TIMEOUT_US_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             tone_in,
    output logic [CNT_W-1:0] period_us,
    output logic [CNT_W-1:0] high_us,
    output logic             period_valid,
    output logic             tone_present,
    output logic             tone_lost,
    output tone_dbg_t        dbg
);

    localparam logic [5:0]       PRESC_MAX = 6'(CLK_F - 1);
    localparam logic [CNT_W-1:0] TIMEOUT   = CNT_W'(TIMEOUT_US);

    logic             level;
    logic             rise;
    logic             fall;
    logic [5:0]       presc;
    logic             tick;
    logic [CNT_W-1:0] us_cnt;
    logic [CNT_W-1:0] us_now;
    logic [CNT_W-1:0] high_cap;
    tone_state_e      state_q;
    tone_state_e      state_d;
    logic             do_report;
    logic             do_lost;
    logic             do_fall;

    sync_edge u_sync (
        .clk   (CLK),
        .rst_n (RST_N),
        .din   (tone_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    assign tick = (presc == PRESC_MAX);
    // An edge landing on a tick counts that tick, giving floor(cycles / CLK_F).
    assign us_now = us_cnt + {{(CNT_W-1){1'b0}}, tick};

    always_comb begin
        dbg       = '0;
        dbg.state = state_q;
        dbg.level = level;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        do_report = 1'b0;
        do_lost   = 1'b0;
        do_fall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                do_fall = fall;
                // A rise in the timeout cycle still completes the measurement.
                if (rise) begin
                    do_report = 1'b1;
                end else if (us_cnt == TIMEOUT) begin
                    do_lost = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            presc        <= '0;
            us_cnt       <= '0;
            high_cap     <= '0;
            period_us    <= '0;
            high_us      <= '0;
            period_valid <= 1'b0;
            tone_present <= 1'b0;
            tone_lost    <= 1'b0;
        end else begin
            period_valid <= do_report;
            tone_lost    <= do_lost;

            if (rise || tick) begin
                presc <= '0;
            end else begin
                presc <= presc + 6'd1;
            end

            if (rise) begin
                us_cnt <= '0;
            end else if (tick && us_cnt != TIMEOUT) begin
                us_cnt <= us_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end

            if (rise) begin
                high_cap <= '0;
            end else if (do_fall) begin
                high_cap <= us_now;
            end

            if (do_report) begin
                period_us    <= us_now;
                high_us      <= high_cap;
                tone_present <= 1'b1;
            end else if (do_lost) begin
                tone_present <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tone_meter.sv
// Scoreboarded bench for tone_meter: randomized and directed square waves are
// scored against a cycle-count model of the expected period/high/timeout events.
module tb_tone_meter;
    import tone_pkg::*;

    localparam int F   = 5;
    localparam int W   = 21;
    localparam int T   = 1100;
    localparam int LIM = T * F + 1;   // longest rise-to-rise gap (cycles) still reported
    localparam int EW  = 2 + 2 * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tone_in;
    logic [W-1:0]  period_us;
    logic [W-1:0]  high_us;
    logic          period_valid;
    logic          tone_present;
    logic          tone_lost;
    tone_dbg_t     dbg;

    always #5 clk = ~clk;

    tone_meter #(.CLK_F(F), .CNT_W(W), .TIMEOUT_US(T)) dut (
        .CLK          (clk),
        .RST_N        (rst_n),
        .tone_in      (tone_in),
        .period_us    (period_us),
        .high_us      (high_us),
        .period_valid (period_valid),
        .tone_present (tone_present),
        .tone_lost    (tone_lost),
        .dbg          (dbg)
    );

    // Entry: {lost, lost_follows_strobe, period_us, high_us}
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] e;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            last_strobe_cyc = 0;

    bit            measuring;
    int            prev_len;
    int            prev_h;
    logic [W-1:0]  last_p;
    logic [W-1:0]  last_h;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #($urandom_range(1, 8));
    endtask

    // Reference model: one call per rising edge of tone_in, knowing the
    // high and low lengths (cycles) of the segment that this rise starts.
    task automatic model_rise(input int h, input int l);
        bit reported;
        reported = 1'b0;
        if (measuring) begin
            last_p = W'(prev_len / F);
            last_h = W'(prev_h / F);
            exp_q.push_back({1'b0, 1'b0, last_p, last_h});
            reported = 1'b1;
        end
        measuring = 1'b1;
        if (h + l > LIM) begin
            exp_q.push_back({1'b1, reported, last_p, last_h});
            measuring = 1'b0;
        end
        prev_len = h + l;
        prev_h   = h;
    endtask

    task automatic seg(input int h, input int l);
        model_rise(h, l);
        tone_in = 1'b1;
        step(h);
        tone_in = 1'b0;
        step(l);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_period_us"}, period_us, 0);
        chk({tag, "_high_us"}, high_us, 0);
        chk({tag, "_valid"}, period_valid, 0);
        chk({tag, "_present"}, tone_present, 0);
        chk({tag, "_lost"}, tone_lost, 0);
        chk({tag, "_state"}, dbg.state, IDLE);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && (period_valid === 1'b1 || tone_lost === 1'b1)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: valid=%0b lost=%0b period=%0d high=%0d, nothing expected (cycle %0d)",
                         period_valid, tone_lost, period_us, high_us, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("event_is_lost", tone_lost, e[EW-1]);
                chk("event_is_valid", period_valid, !e[EW-1]);
                chk("period_us", period_us, e[2*W-1:W]);
                chk("high_us", high_us, e[W-1:0]);
                chk("tone_present", tone_present, !e[EW-1]);
                if (e[EW-1] && e[EW-2]) begin
                    chk("lost_delay_cycles", cyc - last_strobe_cyc, LIM);
                end
                if (!e[EW-1]) begin
                    last_strobe_cyc = cyc;
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        tone_in   = 1'b0;
        measuring = 1'b0;
        prev_len  = 0;
        prev_h    = 0;
        last_p    = '0;
        last_h    = '0;

        repeat (50) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #2;
        chk_zero("idle");

        // Steady tone: 1000 us period, 500 us high.
        for (int i = 0; i < 5; i++) seg(2500, 2500);
        // 3 us high / 7 us low.
        for (int i = 0; i < 20; i++) seg(15, 35);
        // Period change 100 us -> 37 us.
        for (int i = 0; i < 4; i++) seg(250, 250);
        for (int i = 0; i < 4; i++) seg(93, 92);
        // Random shapes, including sub-microsecond pulses.
        for (int i = 0; i < 30; i++) seg($urandom_range(1, 300), $urandom_range(1, 300));

        // Rise exactly in the timeout cycle, then one cycle later than that.
        seg(100, LIM - 100);
        seg(100, LIM + 1 - 100);
        for (int i = 0; i < 3; i++) seg(500, 500);

        // Reset 40 us into a 100 us period, during the low phase.
        seg(250, 250);
        seg(250, 250);
        model_rise(150, 350);
        tone_in = 1'b1;
        step(150);
        tone_in = 1'b0;
        step(50);
        chk("queue_empty_before_reset", exp_q.size(), 0);
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        step(3);
        rst_n     = 1'b1;
        measuring = 1'b0;
        last_p    = '0;
        last_h    = '0;
        step(297);
        seg(250, 250);
        seg(250, 250);

        // Final tone then silence long enough to time out.
        seg(250, 6000);

        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (20) @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        chk("final_present", tone_present, 0);
        chk("final_state", dbg.state, IDLE);
        chk("final_period_hold", period_us, 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
